// File: rtl/mylstar_pkg.sv
// Shared types and constants for the NVRAM ioctl save/restore path.
package mylstar_pkg;

  typedef enum logic [1:0] {StIdle, StRdAddr, StRdWait, StRdDone} nvio_state_t;

  localparam logic [7:0] NVRAM_IOCTL_INDEX = 8'd4;
  localparam logic [7:0] NVRAM_FILL        = 8'hFF;

endpackage

// File: rtl/nvram_ioctl_port.sv
// Bridges hps_io upload/download sessions to the NVRAM second port and keeps
// a dirty flag so the OSD knows when the high-score image needs saving.
module nvram_ioctl_port
  import mylstar_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [7:0]  NV_INDEX = NVRAM_IOCTL_INDEX,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              i_clk_sys,
  input  logic              i_reset,
  input  logic              i_ioctl_upload,
  input  logic              i_ioctl_download,
  input  logic [7:0]        i_ioctl_index,
  input  logic              i_ioctl_rd,
  input  logic              i_ioctl_wr,
  input  logic [24:0]       i_ioctl_addr,
  input  logic [7:0]        i_ioctl_dout,
  output logic [7:0]        o_ioctl_din,
  output logic              o_ioctl_wait,
  output logic [ADDR_W-1:0] o_nv_addr,
  input  logic [7:0]        i_nv_rd_data,
  output logic              o_nv_wr,
  output logic [7:0]        o_nv_wr_data,
  output logic              o_busy,
  input  logic              i_cpu_nv_wr,
  output logic              o_dirty
);

  localparam int unsigned       CntW     = 2;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  nvio_state_t       r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]        r_din, w_din_nxt;
  logic              r_wait, w_wait_nxt;
  logic [ADDR_W-1:0] r_nv_addr, w_nv_addr_nxt;
  logic              r_nv_wr, w_nv_wr_nxt;
  logic [7:0]        r_nv_wr_data, w_nv_wr_data_nxt;
  logic              r_busy;
  logic              r_dirty, w_dirty_nxt;
  logic [ADDR_W-1:0] r_last_addr, w_last_addr_nxt;
  logic              r_wrote, w_wrote_nxt;
  logic              r_upload_q, r_download_q;

  logic w_sel, w_in_range, w_rd_req, w_wr_req, w_up_fall, w_dn_fall;

  assign w_sel      = (i_ioctl_index == NV_INDEX);
  assign w_in_range = (i_ioctl_addr[24:ADDR_W] == '0);
  assign w_rd_req   = i_ioctl_rd & i_ioctl_upload & w_sel;
  assign w_wr_req   = i_ioctl_wr & i_ioctl_download & w_sel & w_in_range;
  assign w_up_fall  = r_upload_q & ~i_ioctl_upload & w_sel;
  assign w_dn_fall  = r_download_q & ~i_ioctl_download & w_sel;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_din_nxt        = r_din;
    w_wait_nxt       = r_wait;
    w_nv_addr_nxt    = r_nv_addr;
    w_nv_wr_nxt      = 1'b0;
    w_nv_wr_data_nxt = r_nv_wr_data;
    w_last_addr_nxt  = r_last_addr;
    w_wrote_nxt      = r_wrote;
    w_dirty_nxt      = r_dirty;

    unique case (r_state)
      // Data and wait-release are already registered on entry to StRdDone,
      // so it accepts a new request just like idle.
      StIdle, StRdDone: begin
        w_state_nxt = StIdle;
        if (w_rd_req) begin
          if (w_in_range) begin
            w_state_nxt     = StRdAddr;
            w_nv_addr_nxt   = i_ioctl_addr[ADDR_W-1:0];
            w_last_addr_nxt = i_ioctl_addr[ADDR_W-1:0];
            w_wait_nxt      = 1'b1;
          end else begin
            w_din_nxt = NVRAM_FILL;
          end
        end else if (w_wr_req) begin
          w_nv_wr_nxt      = 1'b1;
          w_nv_addr_nxt    = i_ioctl_addr[ADDR_W-1:0];
          w_nv_wr_data_nxt = i_ioctl_dout;
          w_wrote_nxt      = 1'b1;
        end
      end
      StRdAddr: begin
        w_state_nxt = StRdWait;
        w_cnt_nxt   = CntW'(RD_LAT - 1);
      end
      StRdWait: begin
        if (r_cnt == '0) begin
          w_state_nxt = StRdDone;
          w_din_nxt   = i_nv_rd_data;
          w_wait_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // A save only counts as complete if the HPS read through the last byte.
    if (w_up_fall && (r_last_addr == LastAddr)) begin
      w_dirty_nxt = 1'b0;
    end
    if (w_dn_fall) begin
      if (r_wrote) begin
        w_dirty_nxt = 1'b0;
      end
      w_wrote_nxt = 1'b0;
    end
    if (i_cpu_nv_wr) begin
      w_dirty_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_din        <= '0;
      r_wait       <= 1'b0;
      r_nv_addr    <= '0;
      r_nv_wr      <= 1'b0;
      r_nv_wr_data <= '0;
      r_busy       <= 1'b0;
      r_dirty      <= 1'b0;
      r_last_addr  <= '0;
      r_wrote      <= 1'b0;
      r_upload_q   <= 1'b0;
      r_download_q <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_din        <= w_din_nxt;
      r_wait       <= w_wait_nxt;
      r_nv_addr    <= w_nv_addr_nxt;
      r_nv_wr      <= w_nv_wr_nxt;
      r_nv_wr_data <= w_nv_wr_data_nxt;
      r_busy       <= w_sel & (i_ioctl_upload | i_ioctl_download);
      r_dirty      <= w_dirty_nxt;
      r_last_addr  <= w_last_addr_nxt;
      r_wrote      <= w_wrote_nxt;
      r_upload_q   <= i_ioctl_upload;
      r_download_q <= i_ioctl_download;
    end
  end

  assign o_ioctl_din  = r_din;
  assign o_ioctl_wait = r_wait;
  assign o_nv_addr    = r_nv_addr;
  assign o_nv_wr      = r_nv_wr;
  assign o_nv_wr_data = r_nv_wr_data;
  assign o_busy       = r_busy;
  assign o_dirty      = r_dirty;

endmodule

// File: tb/tb_nvram_ioctl_port.sv
// Bench for nvram_ioctl_port: instance A uses a 1-cycle NVRAM, instance B a
// 3-cycle NVRAM; both see the same HPS stimulus and are checked against a model.
module tb_nvram_ioctl_port;
  import mylstar_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, upload = 1'b0, download = 1'b0, rd = 1'b0, wr = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  index = 8'd4, dout = 8'd0;
  logic [24:0] addr = 25'd0;

  logic [7:0] din_a, din_b, nv_addr_a, nv_addr_b, wdata_a, wdata_b, rd_data_a, rd_data_b;
  logic       wait_a, wait_b, nv_wr_a, nv_wr_b, busy_a, busy_b, dirty_a, dirty_b;

  logic [7:0] mem [256];
  logic [7:0] pipe_b [3];
  logic [7:0] ref_mem [256];

  int   n_tests = 0;
  int   n_fail = 0;
  int   wr_pulses = 0;
  logic exp_dirty = 1'b0;
  logic [7:0] exp_last = 8'd0;

  nvram_ioctl_port #(.ADDR_W(8), .NV_INDEX(8'd4), .RD_LAT(1)) u_dut_a (
    .i_clk_sys(clk), .i_reset(reset), .i_ioctl_upload(upload), .i_ioctl_download(download),
    .i_ioctl_index(index), .i_ioctl_rd(rd), .i_ioctl_wr(wr), .i_ioctl_addr(addr),
    .i_ioctl_dout(dout), .o_ioctl_din(din_a), .o_ioctl_wait(wait_a), .o_nv_addr(nv_addr_a),
    .i_nv_rd_data(rd_data_a), .o_nv_wr(nv_wr_a), .o_nv_wr_data(wdata_a), .o_busy(busy_a),
    .i_cpu_nv_wr(cpu_wr), .o_dirty(dirty_a)
  );

  nvram_ioctl_port #(.ADDR_W(8), .NV_INDEX(8'd4), .RD_LAT(3)) u_dut_b (
    .i_clk_sys(clk), .i_reset(reset), .i_ioctl_upload(upload), .i_ioctl_download(download),
    .i_ioctl_index(index), .i_ioctl_rd(rd), .i_ioctl_wr(wr), .i_ioctl_addr(addr),
    .i_ioctl_dout(dout), .o_ioctl_din(din_b), .o_ioctl_wait(wait_b), .o_nv_addr(nv_addr_b),
    .i_nv_rd_data(rd_data_b), .o_nv_wr(nv_wr_b), .o_nv_wr_data(wdata_b), .o_busy(busy_b),
    .i_cpu_nv_wr(cpu_wr), .o_dirty(dirty_b)
  );

  // Board NVRAM: written through instance A, read with each instance's latency.
  always @(posedge clk) begin
    if (nv_wr_a) mem[nv_addr_a] <= wdata_a;
    rd_data_a <= mem[nv_addr_a];
    pipe_b[0] <= mem[nv_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rd_data_b = pipe_b[2];

  always @(negedge clk) if (nv_wr_a) wr_pulses <= wr_pulses + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_pulse();
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    exp_dirty = 1'b1;
    n_tests++;
    if (dirty_a !== 1'b1 || dirty_b !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_set_dirty: dirty=%b/%b required 1", dirty_a, dirty_b);
    end
  endtask

  task automatic do_read(input logic [24:0] a, input bit drop_up);
    logic [7:0] prev_a, prev_b, exp;
    int done_a, done_b;
    bit inr;
    inr = (a[24:8] == 17'd0);
    exp = inr ? ref_mem[a[7:0]] : NVRAM_FILL;
    prev_a = nv_addr_a;
    prev_b = nv_addr_b;
    rd = 1'b1;
    addr = a;
    tick();
    rd = 1'b0;
    if (drop_up) upload = 1'b0;
    if (!inr) begin
      n_tests++;
      if (din_a !== 8'hFF || din_b !== 8'hFF || wait_a !== 1'b0 || wait_b !== 1'b0 ||
          nv_addr_a !== prev_a || nv_addr_b !== prev_b) begin
        n_fail++;
        $display("FAIL oor_read addr=%h: din=%h/%h wait=%b/%b nv_addr=%h/%h required ff ff 0 0 %h/%h",
                 a, din_a, din_b, wait_a, wait_b, nv_addr_a, nv_addr_b, prev_a, prev_b);
      end
    end else begin
      exp_last = a[7:0];
      n_tests++;
      if (wait_a !== 1'b1 || wait_b !== 1'b1 || nv_addr_a !== a[7:0] || nv_addr_b !== a[7:0]) begin
        n_fail++;
        $display("FAIL read_start addr=%h: wait=%b/%b nv_addr=%h/%h required 1 1 %h",
                 a, wait_a, wait_b, nv_addr_a, nv_addr_b, a[7:0]);
      end
      done_a = 0;
      done_b = 0;
      for (int n = 2; n <= 12 && (done_a == 0 || done_b == 0); n++) begin
        tick();
        if (done_a == 0 && wait_a == 1'b0) done_a = n;
        if (done_b == 0 && wait_b == 1'b0) done_b = n;
      end
      n_tests++;
      if (done_a != 3 || done_b != 5) begin
        n_fail++;
        $display("FAIL read_latency addr=%h: wait dropped at cycle %0d/%0d required 3/5",
                 a, done_a, done_b);
      end
      n_tests++;
      if (din_a !== exp || din_b !== exp) begin
        n_fail++;
        $display("FAIL read_data addr=%h: din=%h/%h required %h", a, din_a, din_b, exp);
      end
    end
    if (drop_up && exp_last == 8'hFF) exp_dirty = 1'b0;
  endtask

  task automatic end_upload(input bit cpu);
    upload = 1'b0;
    cpu_wr = cpu;
    tick();
    cpu_wr = 1'b0;
    if (exp_last == 8'hFF) exp_dirty = 1'b0;
    if (cpu) exp_dirty = 1'b1;
    n_tests++;
    if (dirty_a !== exp_dirty || dirty_b !== exp_dirty) begin
      n_fail++;
      $display("FAIL upload_end_dirty last=%h: dirty=%b/%b required %b",
               exp_last, dirty_a, dirty_b, exp_dirty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (din_a !== 8'd0 || wait_a !== 1'b0 || nv_addr_a !== 8'd0 || nv_wr_a !== 1'b0 ||
        wdata_a !== 8'd0 || busy_a !== 1'b0 || dirty_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: din=%h wait=%b addr=%h wr=%b wdata=%h busy=%b dirty=%b required all 0",
               din_a, wait_a, nv_addr_a, nv_wr_a, wdata_a, busy_a, dirty_a);
    end
    n_tests++;
    if (din_b !== 8'd0 || wait_b !== 1'b0 || nv_addr_b !== 8'd0 || nv_wr_b !== 1'b0 ||
        wdata_b !== 8'd0 || busy_b !== 1'b0 || dirty_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: din=%h wait=%b addr=%h wr=%b wdata=%h busy=%b dirty=%b required all 0",
               din_b, wait_b, nv_addr_b, nv_wr_b, wdata_b, busy_b, dirty_b);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_download();
    int base;
    logic [7:0] d;
    cpu_pulse();
    index = 8'd4;
    download = 1'b1;
    tick();
    n_tests++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL download_busy: busy=%b/%b required 1", busy_a, busy_b);
    end
    base = wr_pulses;
    for (int i = 0; i < 256; i++) begin
      d = (i == 8'h12) ? 8'hA5 : 8'($urandom);
      ref_mem[i] = d;
      wr = 1'b1;
      addr = 25'(i);
      dout = d;
      tick();
      n_tests++;
      if (nv_wr_a !== 1'b1 || nv_addr_a !== 8'(i) || wdata_a !== d ||
          nv_wr_b !== 1'b1 || nv_addr_b !== 8'(i) || wdata_b !== d) begin
        n_fail++;
        $display("FAIL download_write i=%0d: wr=%b/%b addr=%h/%h data=%h/%h required 1 %h %h",
                 i, nv_wr_a, nv_wr_b, nv_addr_a, nv_addr_b, wdata_a, wdata_b, 8'(i), d);
      end
    end
    addr = 25'h100;
    dout = 8'h5A;
    tick();
    wr = 1'b0;
    tick();
    n_tests++;
    if (nv_wr_a !== 1'b0 || nv_wr_b !== 1'b0) begin
      n_fail++;
      $display("FAIL download_oor_drop: nv_wr=%b/%b required 0", nv_wr_a, nv_wr_b);
    end
    download = 1'b0;
    tick();
    exp_dirty = 1'b0;
    n_tests++;
    if (dirty_a !== exp_dirty || dirty_b !== exp_dirty || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL download_end: dirty=%b/%b busy=%b/%b required 0 0", dirty_a, dirty_b,
               busy_a, busy_b);
    end
    tick();
    n_tests++;
    if (wr_pulses - base != 256) begin
      n_fail++;
      $display("FAIL download_pulses: %0d pulses required 256", wr_pulses - base);
    end
  endtask

  task automatic test_rom_index();
    int base, bad;
    base = wr_pulses;
    bad = 0;
    index = 8'd0;
    download = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr = 1'b1;
      addr = 25'(i);
      dout = 8'($urandom);
      tick();
      if (busy_a || busy_b || nv_wr_a || nv_wr_b) bad++;
    end
    wr = 1'b0;
    download = 1'b0;
    upload = 1'b1;
    rd = 1'b1;
    addr = 25'h5;
    tick();
    rd = 1'b0;
    if (busy_a || busy_b || wait_a || wait_b) bad++;
    tick();
    if (wait_a || wait_b) bad++;
    upload = 1'b0;
    tick();
    index = 8'd4;
    n_tests++;
    if (bad != 0 || wr_pulses != base || dirty_a !== exp_dirty) begin
      n_fail++;
      $display("FAIL rom_index_inert: %0d active cycles, %0d pulses, dirty=%b required 0 0 %b",
               bad, wr_pulses - base, dirty_a, exp_dirty);
    end
  endtask

  task automatic test_upload_read();
    upload = 1'b1;
    tick();
    n_tests++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL upload_busy: busy=%b/%b required 1", busy_a, busy_b);
    end
    do_read(25'h12, 1'b0);
    for (int i = 0; i < 8; i++) do_read(25'($urandom_range(0, 254)), 1'b0);
    do_read(25'h100, 1'b0);
    do_read({17'($urandom_range(1, 131071)), 8'($urandom)}, 1'b0);
    end_upload(1'b0);
  endtask

  task automatic test_dirty();
    cpu_pulse();
    upload = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) do_read(25'(i), 1'b0);
    end_upload(1'b0);
    cpu_pulse();
    upload = 1'b1;
    tick();
    for (int i = 0; i <= 8'h80; i++) do_read(25'(i), 1'b0);
    end_upload(1'b0);
    upload = 1'b1;
    tick();
    do_read(25'hFF, 1'b0);
    end_upload(1'b1);
    download = 1'b1;
    tick();
    download = 1'b0;
    tick();
    n_tests++;
    if (dirty_a !== exp_dirty || dirty_b !== exp_dirty) begin
      n_fail++;
      $display("FAIL empty_download_dirty: dirty=%b/%b required %b", dirty_a, dirty_b, exp_dirty);
    end
  endtask

  task automatic test_back_to_back_abort();
    upload = 1'b1;
    tick();
    do_read(25'($urandom_range(0, 254)), 1'b0);
    do_read(25'hFF, 1'b1);
    n_tests++;
    if (dirty_a !== exp_dirty || dirty_b !== exp_dirty) begin
      n_fail++;
      $display("FAIL abort_dirty: dirty=%b/%b required %b", dirty_a, dirty_b, exp_dirty);
    end
  endtask

  task automatic test_reset_midread();
    upload = 1'b1;
    tick();
    rd = 1'b1;
    addr = 25'h34;
    tick();
    rd = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_dirty = 1'b0;
    exp_last = 8'd0;
    n_tests++;
    if (wait_a !== 1'b0 || wait_b !== 1'b0 || din_a !== 8'd0 || din_b !== 8'd0 ||
        nv_addr_b !== 8'd0 || busy_b !== 1'b0 || dirty_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midread: wait=%b/%b din=%h/%h addr=%h busy=%b dirty=%b required all 0",
               wait_a, wait_b, din_a, din_b, nv_addr_b, busy_b, dirty_b);
    end
    tick();
    do_read(25'h34, 1'b0);
    end_upload(1'b0);
  endtask

  initial begin
    test_reset();
    test_download();
    test_rom_index();
    test_upload_read();
    test_dirty();
    test_back_to_back_abort();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
